// File: rtl/gfg_spi_master.sv
// SPI mode-0 master issuing single-register write/read frames to the gfg register slave.
// Frame = command byte, optional read turnaround zeros, then data MSB first; all outputs registered.
module gfg_spi_master #(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned REGISTER_WIDTH  = 32,
  parameter int unsigned TURNAROUND_BITS = 8
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic                      i_start,
  input  logic                      i_rw,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [REGISTER_WIDTH-1:0] i_wdata,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [REGISTER_WIDTH-1:0] o_rdata,
  output logic                      o_spi_clk,
  output logic                      o_spi_mosi,
  input  logic                      i_spi_miso,
  output logic                      o_spi_ss_n
);

  localparam int unsigned CmdW = ADDR_WIDTH + 2;
  localparam int unsigned MaxN = CmdW + TURNAROUND_BITS + REGISTER_WIDTH;
  localparam int unsigned BitW = $clog2(MaxN);
  localparam int unsigned PhW  = $clog2(CLK_DIV);

  localparam logic [PhW-1:0]  PhLast = PhW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] LastWr = BitW'(CmdW + REGISTER_WIDTH - 1);
  localparam logic [BitW-1:0] LastRd = BitW'(MaxN - 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold, StGap} state_e;

  state_e                    state_q, state_d;
  logic [PhW-1:0]            phase_q, phase_d;
  logic [BitW-1:0]           bit_q, bit_d;
  logic                      rw_q, rw_d;
  logic [MaxN-1:0]           tx_q, tx_d;
  logic [REGISTER_WIDTH-1:0] rx_q, rx_d;
  logic                      sclk_q, sclk_d;
  logic                      mosi_q, mosi_d;
  logic                      ss_n_q, ss_n_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [REGISTER_WIDTH-1:0] rdata_q, rdata_d;

  logic            phase_last;
  logic            bit_last;
  logic [MaxN-1:0] frame;

  assign phase_last = (phase_q == PhLast);
  assign bit_last   = (bit_q == (rw_q ? LastWr : LastRd));

  // Left-aligned frame; reads leave turnaround and data slots zero.
  always_comb begin
    frame = '0;
    frame[MaxN-1 -: CmdW] = {i_rw, 1'b0, i_addr};
    if (i_rw) begin
      frame[MaxN-1-CmdW -: REGISTER_WIDTH] = i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      rw_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      rw_q    <= rw_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Every non-idle transition lands on phase_last, so the phase counter restarts at 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_start) state_d = StShift;
      StShift: if (phase_last && sclk_q && bit_last) state_d = StHold;
      StHold:  if (phase_last) state_d = StGap;
      StGap:   if (phase_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    phase_d = (state_q == StIdle || phase_last) ? '0 : phase_q + PhW'(1);
    bit_d   = bit_q;
    rw_d    = rw_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          rw_d   = i_rw;
          tx_d   = frame;
          mosi_d = frame[MaxN-1];
          bit_d  = '0;
          sclk_d = 1'b0;
          ss_n_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      StShift: begin
        if (phase_last) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[REGISTER_WIDTH-2:0], i_spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_last) begin
              mosi_d = 1'b0;
            end else begin
              bit_d  = bit_q + BitW'(1);
              tx_d   = tx_q << 1;
              mosi_d = tx_q[MaxN-2];
            end
          end
        end
      end
      StHold: begin
        if (phase_last) begin
          ss_n_d = 1'b1;
          done_d = 1'b1;
          if (!rw_q) begin
            rdata_d = rx_q;
          end
        end
      end
      StGap: begin
        if (phase_last) begin
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rdata    = rdata_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_gfg_spi_master.sv
// Bench for gfg_spi_master: behavioural register slave on the SPI pins plus a scoreboard of
// expected frames, read data and frame timing checked at every o_done.
module tb_gfg_spi_master;

  localparam int D = 4;

  logic        i_clk, i_arst_n, i_start, i_rw;
  logic [5:0]  i_addr;
  logic [31:0] i_wdata;
  logic        o_busy, o_done;
  logic [31:0] o_rdata;
  logic        o_spi_clk, o_spi_mosi, spi_miso, o_spi_ss_n;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic        rw;
    logic [47:0] frame;
    int          n;
    logic [31:0] rdata;
    int          a;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_regs[32];
  logic [31:0] last_rd_exp = '0;

  // Slave state
  logic [31:0] s_regs[32];
  logic [47:0] s_sh = '0;
  int          s_cnt = 0;
  logic [7:0]  s_cmd = '0;
  logic        s_sclk_prev = 1'b0;

  // Monitor state
  int   last_a = 0, last_n = 0, ss_cnt = 0, gap_cnt = 0, last_gap = 0;
  logic prev_busy = 1'b0, prev_ss = 1'b1, prev_sclk = 1'b0;

  gfg_spi_master #(
    .CLK_DIV        (D),
    .ADDR_WIDTH     (6),
    .REGISTER_WIDTH (32),
    .TURNAROUND_BITS(8)
  ) dut (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .i_start   (i_start),
    .i_rw      (i_rw),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_rdata   (o_rdata),
    .o_spi_clk (o_spi_clk),
    .o_spi_mosi(o_spi_mosi),
    .i_spi_miso(spi_miso),
    .o_spi_ss_n(o_spi_ss_n)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: counts a rising SCLK one clock after it appears, which is after the master sampled.
  initial begin
    for (int i = 0; i < 32; i++) s_regs[i] = 32'h1000_0000 + i;
    s_regs[5] = 32'hDEAD_BEEF;
    forever begin
      @(posedge i_clk);
      if (o_spi_ss_n) begin
        if (s_cnt == 40 && s_sh[39]) s_regs[s_sh[36:32]] = s_sh[31:0];
        s_cnt = 0;
      end else if (!s_sclk_prev && o_spi_clk) begin
        s_sh = {s_sh[46:0], o_spi_mosi};
        s_cnt++;
        if (s_cnt == 8) s_cmd = s_sh[7:0];
      end
      s_sclk_prev = o_spi_clk;
    end
  end

  // Non-zero junk during command/turnaround so a master that keeps those bits is visible.
  always_comb begin
    spi_miso = 1'b0;
    if (!o_spi_ss_n) begin
      if (s_cnt < 16) spi_miso = (s_cnt % 2) == 1;
      else if (s_cnt < 48 && !s_cmd[7]) spi_miso = s_regs[s_cmd[4:0]][47 - s_cnt];
    end
  end

  // Scoreboard monitor; cycle k after an accept edge A is observed when cyc == A + k - 1.
  initial begin
    exp_t        e;
    logic [47:0] got_frame;
    forever begin
      @(negedge i_clk);
      if (!i_arst_n) begin
        ss_cnt  = 0;
        gap_cnt = 0;
      end else begin
        if (o_spi_ss_n != prev_ss) check_eq("sclk_at_ss_edge", {62'h0, o_spi_clk, prev_sclk}, 64'h0);
        if (!o_spi_ss_n) ss_cnt++;
        if (o_spi_ss_n) gap_cnt++;
        else if (gap_cnt != 0) begin
          last_gap = gap_cnt;
          gap_cnt  = 0;
        end
        if (o_done) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_done", 64'h1, 64'h0);
          end else begin
            e = sb_q.pop_front();
            got_frame = e.rw ? {8'h00, s_sh[39:0]} : s_sh;
            check_eq("mosi_frame", got_frame, e.frame);
            check_eq("sclk_edges", 64'(s_cnt), 64'(e.n));
            check_eq("rdata", o_rdata, e.rdata);
            check_eq("done_cycle", 64'(cyc - e.a), 64'((2 * e.n + 1) * D));
            check_eq("ss_low_cycles", 64'(ss_cnt), 64'((2 * e.n + 1) * D));
            last_a = e.a;
            last_n = e.n;
          end
          ss_cnt = 0;
        end
        if (prev_busy && !o_busy) check_eq("busy_fall", 64'(cyc - last_a), 64'((2 * last_n + 2) * D));
      end
      prev_busy = o_busy;
      prev_ss   = o_spi_ss_n;
      prev_sclk = o_spi_clk;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (o_busy && k < 2000) begin
      @(negedge i_clk);
      k++;
    end
    if (o_busy) check_eq("idle_timeout", 64'h1, 64'h0);
  endtask

  task automatic start_txn(input logic rw, input logic [5:0] addr, input logic [31:0] wdata,
                           output int a);
    exp_t e;
    wait_idle();
    i_start = 1'b1;
    i_rw    = rw;
    i_addr  = addr;
    i_wdata = wdata;
    a       = cyc + 1;
    e.rw = rw;
    e.a  = a;
    if (rw) begin
      e.frame = {8'h00, 2'b10, addr, wdata};
      e.n     = 40;
      e.rdata = last_rd_exp;
      exp_regs[addr[4:0]] = wdata;
    end else begin
      e.frame     = {2'b00, addr, 40'h0};
      e.n         = 48;
      last_rd_exp = exp_regs[addr[4:0]];
      e.rdata     = last_rd_exp;
    end
    sb_q.push_back(e);
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  initial begin
    int a0, a1;
    int k;
    exp_t drop;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h1000_0000 + i;
    exp_regs[5] = 32'hDEAD_BEEF;
    i_arst_n = 1'b0;
    i_start  = 1'b0;
    i_rw     = 1'b0;
    i_addr   = '0;
    i_wdata  = '0;
    repeat (3) @(negedge i_clk);
    i_arst_n = 1'b1;
    @(negedge i_clk);
    check_eq("rst_ss_n", o_spi_ss_n, 1'b1);
    check_eq("rst_sclk", o_spi_clk, 1'b0);
    check_eq("rst_mosi", o_spi_mosi, 1'b0);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_done", o_done, 1'b0);
    check_eq("rst_rdata", o_rdata, 32'h0);

    // Basic write, then read of the preloaded register.
    start_txn(1'b1, 6'd0, 32'h0000_0028, a0);
    start_txn(1'b0, 6'd5, 32'h0, a0);
    wait_idle();

    // Starts and wdata changes during a frame are ignored.
    start_txn(1'b1, 6'd3, 32'hA5A5_0F0F, a0);
    for (int i = 0; i < 5; i++) begin
      repeat (37) @(negedge i_clk);
      i_start = 1'b1;
      i_rw    = 1'b0;
      i_wdata = $urandom;
      @(negedge i_clk);
      i_start = 1'b0;
    end
    wait_idle();
    k = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_busy || !o_spi_ss_n) k++;
    end
    check_eq("no_restart", 64'(k), 64'h0);

    // Back-to-back: GAP plus the single idle accept cycle keep SS_n high.
    start_txn(1'b1, 6'd31, 32'h0000_0001, a0);
    start_txn(1'b0, 6'd3, 32'h0, a1);
    check_eq("b2b_accept_dist", 64'(a1 - a0), 64'((2 * 40 + 2) * D + 1));
    check_eq("b2b_gap", 64'(last_gap), 64'(D + 1));
    wait_idle();

    // Loopback: write registers 0..5, read them back.
    for (int i = 0; i < 6; i++) start_txn(1'b1, 6'(i), 32'h5A00_0000 ^ (32'h0101_0101 * (i + 3)), a0);
    for (int i = 0; i < 6; i++) start_txn(1'b0, 6'(i), 32'h0, a0);
    wait_idle();

    // Reset in the middle of a read.
    start_txn(1'b0, 6'd1, 32'h0, a0);
    k = 0;
    while (s_cnt != 20 && k < 2000) begin
      @(negedge i_clk);
      k++;
    end
    check_eq("reached_bit20", 64'(s_cnt), 64'd20);
    i_arst_n = 1'b0;
    #1;
    check_eq("midrst_ss_n", o_spi_ss_n, 1'b1);
    check_eq("midrst_sclk", o_spi_clk, 1'b0);
    check_eq("midrst_busy", o_busy, 1'b0);
    check_eq("midrst_rdata", o_rdata, 32'h0);
    drop = sb_q.pop_front();
    last_rd_exp = '0;
    repeat (3) @(negedge i_clk);
    i_arst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    check_eq("post_rst_rdata", o_rdata, 32'h0);
    start_txn(1'b0, 6'd2, 32'h0, a0);
    wait_idle();
    check_eq("final_rdata", o_rdata, exp_regs[2]);
    check_eq("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
